serial_deser16: RTL and testbench
=================================

Name: serial_deser16

Overview:
- Serial-to-parallel receiver: collects a 16-bit word one bit per accepted beat, then presents it on a parallel output with a valid/ready handshake.
- Serves as the receive end of the team's mux16-driven serial link. The transmitter walks a 4-bit select across 16 inputs; this block walks a 4-bit slot counter across 16 capture flops.
- Sits between the serial link and the ALU operand registers.

Parameters:
- LSB_FIRST, 1, 1: the first received bit lands in data_out[0]; 0: the first received bit lands in data_out[15].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- sin  in  1  serial data bit
- sin_valid  in  1  sin is sampled on this clock edge
- sof  in  1  start of frame; qualified by sin_valid; marks the first bit of a word
- data_out  out  16  last completed word
- out_valid  out  1  data_out holds an unconsumed word
- out_ready  in  1  consumer accepts data_out when out_valid=1
- busy  out  1  a frame is in progress
- frame_err  out  1  one-cycle pulse: frame aborted by an early sof
- overrun  out  1  sticky: a completed word was dropped
- parity_err  out  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, slot counter cnt=0, shadow register=0.
  - data_out=16'h0000; out_valid, busy, frame_err, overrun, parity_err all 0.
  - A partial frame is discarded. Reset released mid-stream: bits without sof are ignored until the next sof.
- Beat: an edge with sin_valid=1. No beat means no state change, except for the output handshake.
- Slot mapping: slot = cnt when LSB_FIRST=1; slot = 15-cnt when LSB_FIRST=0. The beat writes sin into shadow[slot].
- IDLE:
  - beat with sof=1: write slot for cnt=0, set cnt=1, go to RECV.
  - beat with sof=0: ignored.
- RECV:
  - beat with sof=0: capture, cnt+=1.
  - beat with cnt==15: this is the final bit. The frame completes, cnt wraps to 0, go to IDLE (PAR if parity is enabled).
  - beat with sof=1: frame_err pulses for 1 cycle. Partial word discarded, shadow cleared. This bit is captured as slot 0, cnt=1, state stays RECV.
- busy = (state != IDLE).
- Completion: the word is copied to data_out and out_valid=1, both visible the cycle after the final-bit edge (latency 1 cycle).
- Handshake:
  - out_valid & out_ready on an edge: out_valid clears.
  - data_out holds its value until the next delivery.
- Simultaneous completion and handshake (out_valid=1, out_ready=1, completion on the same edge): the new word loads and out_valid stays 1. No overrun.
- Completion while out_valid=1 and out_ready=0: the new word is dropped, data_out is unchanged, overrun sets. overrun clears only on reset.
- Back-to-back frames: sof is accepted on the beat immediately after a final bit, with no idle cycle needed.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_DESER16_PARITY_EN.
- Defined:
  - After the 16th bit the block enters PAR and the next beat carries an even-parity bit (XOR of 16 data bits and parity bit = 0).
  - Match: deliver the word exactly as for a normal completion.
  - Mismatch: parity_err pulses 1 cycle, the word is dropped, out_valid is unchanged, overrun is not affected.
  - sof during PAR: frame_err pulse and restart, as in RECV.
  - busy stays 1 in PAR.
- Undefined: no PAR state; the frame completes on the 16th bit; parity_err is tied to 0. The port still exists.

Test Plan:
1. Reset, then 16 beats of 16'hA5C3 LSB-first (sof on beat 0), out_ready=0. Expect data_out=16'hA5C3 with out_valid=1 one cycle after the last beat, and busy=0. Then out_ready=1 for 1 cycle: out_valid→0 and data_out stays 16'hA5C3.
2. LSB_FIRST=0, same bit stream as test 1. Expect data_out=16'hC3A5.
3. With out_valid held and out_ready=0, send a second frame 16'h1234. Expect data_out=16'hA5C3 and overrun=1. Repeat with out_ready=1 on the completion edge: expect data_out=16'h1234, out_valid=1, overrun=0.
4. Send 7 bits, then a new sof frame of 16'hFFFF. Expect frame_err high for exactly 1 cycle and data_out=16'hFFFF.
5. Pull rst_n low mid-frame after 9 bits. Expect all outputs 0 immediately. Then 5 beats without sof: expect no state change and busy=0.
6. With SERIAL_DESER16_PARITY_EN:
   - 16'h0001 + parity 1: delivered.
   - 16'h0001 + parity 0: parity_err pulse, out_valid stays 0.

Source files
------------

// File: rtl/serial_deser16.sv
// serial_deser16 -- serial-to-parallel receiver for the mux16 serial link.
//
// Collects one bit per accepted beat (sin_valid=1) into a 16-slot shadow
// register, walking a 4-bit slot counter. A word starts with sof. A completed
// word is presented on data_out with a valid/ready handshake one cycle after
// the final-bit edge.
//
// Parameters:
//   LSB_FIRST  1: first bit -> data_out[0];  0: first bit -> data_out[15]
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   sin          serial data bit
//   sin_valid    sin is sampled on this edge (a "beat")
//   sof          start of frame, qualified by sin_valid
//   data_out     last delivered word
//   out_valid    data_out holds an unconsumed word
//   out_ready    consumer accepts data_out when out_valid=1
//   busy         a frame is in progress
//   frame_err    1-cycle pulse: frame restarted by an early sof
//   overrun      sticky: a completed word was dropped (clears on reset)
//   parity_err   1-cycle pulse: parity mismatch (0 unless parity built in)
//
// Build option:
//   SERIAL_DESER16_PARITY_EN  adds a PAR state: the beat after the 16th data
//   bit carries an even-parity bit; a mismatch drops the word.
//
// All outputs come straight from flops.

module serial_deser16 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        sin_valid,
  input  logic        sof,
  output logic [15:0] data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err
);

  typedef enum logic [1:0] {IDLE, RECV, PAR} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] data_out_q, data_out_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        parity_err_q, parity_err_d;
  logic        complete;

  function automatic logic [3:0] slot_of(input logic [3:0] c);
    return LSB_FIRST ? c : (4'd15 - c);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    complete     = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (sin_valid) begin
      if (sof) begin
        // sof always (re)starts a frame; it is an error only mid-frame.
        frame_err_d                = (state_q != IDLE);
        shadow_d                   = '0;
        shadow_d[slot_of(4'd0)]    = sin;
        cnt_d                      = 4'd1;
        state_d                    = RECV;
      end else begin
        case (state_q)
          RECV: begin
            shadow_d[slot_of(cnt_q)] = sin;
            if (cnt_q == 4'd15) begin
              cnt_d = 4'd0;
`ifdef SERIAL_DESER16_PARITY_EN
              state_d = PAR;
`else
              state_d  = IDLE;
              complete = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
`ifdef SERIAL_DESER16_PARITY_EN
          PAR: begin
            state_d = IDLE;
            // Even parity over data plus parity bit must XOR to zero.
            if (^{shadow_q, sin}) parity_err_d = 1'b1;
            else                  complete     = 1'b1;
          end
`endif
          default: ;  // IDLE without sof: ignored
        endcase
      end
    end

    // A word consumed on this same edge frees the output for the new one.
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        data_out_d  = shadow_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_deser16.sv
// Directed bench for serial_deser16. Two instances share one stimulus stream:
// u_lsb (LSB_FIRST=1) and u_msb (LSB_FIRST=0). Inputs change on the falling
// edge, outputs are checked on the falling edge.

module tb_serial_deser16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b0, sin_valid = 1'b0, sof = 1'b0, out_ready = 1'b0;
  logic [15:0] d_lsb, d_msb;
  logic        v_lsb, v_msb, b_lsb, b_msb, fe_lsb, fe_msb, ov_lsb, ov_msb, pe_lsb, pe_msb;

  int n_cmp = 0, n_err = 0;
  int fe_cnt = 0, pe_cnt = 0;
  bit bad_par = 1'b0;

  always #5 clk = ~clk;

  serial_deser16 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .data_out(d_lsb), .out_valid(v_lsb), .out_ready(out_ready), .busy(b_lsb),
    .frame_err(fe_lsb), .overrun(ov_lsb), .parity_err(pe_lsb));

  serial_deser16 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .data_out(d_msb), .out_valid(v_msb), .out_ready(out_ready), .busy(b_msb),
    .frame_err(fe_msb), .overrun(ov_msb), .parity_err(pe_msb));

  // Pulse counters on the LSB-first instance.
  always @(negedge clk) begin
    if (fe_lsb) fe_cnt++;
    if (pe_lsb) pe_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic s, input logic f, input logic r);
    @(negedge clk);
    sin = s; sof = f; sin_valid = 1'b1; out_ready = r;
  endtask

  task automatic idle();
    @(negedge clk);
    sin_valid = 1'b0; sof = 1'b0; sin = 1'b0; out_ready = 1'b0;
  endtask

  // n bits of w, w[0] first, sof on the first beat when f=1. out_ready is
  // raised only on the last beat when rl=1. A full 16-bit frame gets its
  // parity beat appended when parity is built in.
  task automatic send_bits(input logic [15:0] w, input int n, input logic f, input logic rl);
    for (int i = 0; i < n; i++) begin
`ifdef SERIAL_DESER16_PARITY_EN
      beat(w[i], f && (i == 0), 1'b0);
`else
      beat(w[i], f && (i == 0), rl && (i == n - 1));
`endif
    end
`ifdef SERIAL_DESER16_PARITY_EN
    if (n == 16) beat((^w) ^ bad_par, 1'b0, rl);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sin_valid = 1'b0; sof = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int fe0;

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_data", d_lsb, 16'h0000);
    chk("rst_valid", {15'd0, v_lsb}, 16'd0);
    chk("rst_busy", {15'd0, b_lsb}, 16'd0);
    chk("rst_flags", {13'd0, fe_lsb, ov_lsb, pe_lsb}, 16'd0);

    // 1/2: A5C3 stream, both bit orders
    send_bits(16'hA5C3, 16, 1'b1, 1'b0);
    idle();
    chk("t1_data", d_lsb, 16'hA5C3);
    chk("t1_valid", {15'd0, v_lsb}, 16'd1);
    chk("t1_busy", {15'd0, b_lsb}, 16'd0);
    chk("t2_data_msb", d_msb, 16'hC3A5);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("t1_hs_valid", {15'd0, v_lsb}, 16'd0);
    chk("t1_hs_hold", d_lsb, 16'hA5C3);

    // 3a: overrun while output is held
    send_bits(16'hA5C3, 16, 1'b1, 1'b0);
    idle();
    send_bits(16'h1234, 16, 1'b1, 1'b0);
    idle();
    chk("t3_drop_data", d_lsb, 16'hA5C3);
    chk("t3_drop_ovr", {15'd0, ov_lsb}, 16'd1);
    chk("t3_drop_valid", {15'd0, v_lsb}, 16'd1);

    // 3b: completion coincides with the handshake
    do_reset();
    send_bits(16'hA5C3, 16, 1'b1, 1'b0);
    idle();
    send_bits(16'h1234, 16, 1'b1, 1'b1);
    idle();
    chk("t3_swap_data", d_lsb, 16'h1234);
    chk("t3_swap_valid", {15'd0, v_lsb}, 16'd1);
    chk("t3_swap_ovr", {15'd0, ov_lsb}, 16'd0);

    // 4: early sof aborts a partial frame
    do_reset();
    fe0 = fe_cnt;
    send_bits(16'h0055, 7, 1'b1, 1'b0);
    idle();
    chk("t4_busy_mid", {15'd0, b_lsb}, 16'd1);
    send_bits(16'hFFFF, 16, 1'b1, 1'b0);
    idle();
    chk("t4_fe_pulses", 16'(fe_cnt - fe0), 16'd1);
    chk("t4_data", d_lsb, 16'hFFFF);
    chk("t4_data_msb", d_msb, 16'hFFFF);
    chk("t4_busy_end", {15'd0, b_lsb}, 16'd0);

    // 5: reset mid-frame, then beats without sof
    send_bits(16'h01FF, 9, 1'b1, 1'b0);
    @(negedge clk);
    sin_valid = 1'b0; sof = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_data", d_lsb, 16'h0000);
    chk("t5_rst_flags", {12'd0, v_lsb, b_lsb, fe_lsb, ov_lsb}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b0);
    idle();
    chk("t5_nosof_busy", {15'd0, b_lsb}, 16'd0);
    chk("t5_nosof_valid", {15'd0, v_lsb}, 16'd0);
    chk("t5_nosof_data", d_lsb, 16'h0000);
    send_bits(16'hBEEF, 16, 1'b1, 1'b0);
    idle();
    chk("t5_after_data", d_lsb, 16'hBEEF);
    chk("t5_after_msb", d_msb, 16'hF77D);

    // Back-to-back frames: sof right after the final beat
    do_reset();
    send_bits(16'h5A0F, 16, 1'b1, 1'b0);
    send_bits(16'h00FF, 16, 1'b1, 1'b1);
    idle();
    chk("b2b_data", d_lsb, 16'h00FF);
    chk("b2b_valid", {15'd0, v_lsb}, 16'd1);
    chk("b2b_ovr", {15'd0, ov_lsb}, 16'd0);

`ifdef SERIAL_DESER16_PARITY_EN
    // 6: parity good / bad
    do_reset();
    send_bits(16'h0001, 16, 1'b1, 1'b0);
    idle();
    chk("t6_good_data", d_lsb, 16'h0001);
    chk("t6_good_valid", {15'd0, v_lsb}, 16'd1);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    bad_par = 1'b1;
    send_bits(16'h0001, 16, 1'b1, 1'b0);
    idle();
    bad_par = 1'b0;
    chk("t6_bad_pe", 16'(pe_cnt), 16'd1);
    chk("t6_bad_valid", {15'd0, v_lsb}, 16'd0);
    chk("t6_bad_ovr", {15'd0, ov_lsb}, 16'd0);
`else
    chk("no_parity_pe", 16'(pe_cnt), 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
